// File: rtl/vdp18_pkg.sv
// Shared VDP18 types: sequencer access slots, display opmodes, CPU I/O request states and
// status register bit positions.
package vdp18_pkg;

  typedef enum logic [3:0] {
    AC_NONE,
    AC_PNT,
    AC_PCT,
    AC_PGT,
    AC_STST,
    AC_SATY,
    AC_SATX,
    AC_SATN,
    AC_SATC,
    AC_SPTH,
    AC_SPTL,
    AC_CPU,
    AC_REFR
  } access_t;

  typedef enum logic [1:0] {
    OPMODE_GRAPH1,
    OPMODE_GRAPH2,
    OPMODE_MULTIC,
    OPMODE_TEXTM
  } opmode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_RDCAP
  } cpuio_state_t;

  localparam int unsigned STAT_F  = 7;
  localparam int unsigned STAT_5S = 6;
  localparam int unsigned STAT_C  = 5;

  function automatic opmode_t decode_opmode(input logic [7:0] reg0, input logic [7:0] reg1);
    if (reg1[4])      return OPMODE_TEXTM;
    else if (reg1[3]) return OPMODE_MULTIC;
    else if (reg0[1]) return OPMODE_GRAPH2;
    else              return OPMODE_GRAPH1;
  endfunction

endpackage

// File: rtl/vdp18_cpuio_strobe.sv
// Falling-edge detector for the CPU read/write strobes; emits registered one-cycle pulses
// split into data-port and control-port accesses by mode_i.
module vdp18_cpuio_strobe (
  input  logic clk_i,
  input  logic reset_i,
  input  logic mode_i,
  input  logic rd_n_i,
  input  logic wr_n_i,
  output logic rd_data_o,
  output logic wr_data_o,
  output logic rd_ctrl_o,
  output logic wr_ctrl_o
);

  logic       rd_n_q, wr_n_q;
  logic       rd_fall, wr_fall;
  logic [3:0] pulse_d, pulse_q;

  assign rd_fall = rd_n_q & ~rd_n_i;
  assign wr_fall = wr_n_q & ~wr_n_i;

  always_comb begin
    pulse_d = {rd_fall & ~mode_i, wr_fall & ~mode_i, rd_fall & mode_i, wr_fall & mode_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      pulse_q <= '0;
    end else begin
      rd_n_q  <= rd_n_i;
      wr_n_q  <= wr_n_i;
      pulse_q <= pulse_d;
    end
  end

  assign rd_data_o = pulse_q[3];
  assign wr_data_o = pulse_q[2];
  assign rd_ctrl_o = pulse_q[1];
  assign wr_ctrl_o = pulse_q[0];

endmodule

// File: rtl/vdp18_cpuio.sv
// VDP18 host-CPU port: register writes, VRAM address/data access through AC_CPU slots,
// status flags and interrupt. Define VDP18_IRQ_EN to drive int_n_o from F & reg1[5].
module vdp18_cpuio
  import vdp18_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mode_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  input  logic [7:0]        cd_i,
  output logic [7:0]        cd_o,
  input  access_t           access_type_i,
  output logic [ADDR_W-1:0] vram_a_o,
  output logic [7:0]        vram_d_o,
  input  logic [7:0]        vram_d_i,
  output logic              vram_we_o,
  input  logic              irq_i,
  input  logic              spr_coll_i,
  input  logic              spr_5th_i,
  input  logic [4:0]        spr_5th_num_i,
  output logic [7:0]        reg0_o,
  output logic [7:0]        reg1_o,
  output logic [7:0]        reg2_o,
  output logic [7:0]        reg3_o,
  output logic [7:0]        reg4_o,
  output logic [7:0]        reg5_o,
  output logic [7:0]        reg6_o,
  output logic [7:0]        reg7_o,
  output opmode_t           opmode_o,
  output logic              int_n_o
);

  logic rd_data, wr_data, rd_ctrl, wr_ctrl;

  vdp18_cpuio_strobe u_strobe (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .mode_i    (mode_i),
    .rd_n_i    (rd_n_i),
    .wr_n_i    (wr_n_i),
    .rd_data_o (rd_data),
    .wr_data_o (wr_data),
    .rd_ctrl_o (rd_ctrl),
    .wr_ctrl_o (wr_ctrl)
  );

  cpuio_state_t      state_d, state_q;
  logic              req_wr_d, req_wr_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [7:0]        buf_d, buf_q;
  logic [7:0]        latch_d, latch_q;
  logic              toggle_d, toggle_q;
  logic [7:0]        cd_d, cd_q;
  logic [7:0]        regs_d [NREGS];
  logic [7:0]        regs_q [NREGS];
  logic              f_d, f_q, s5_d, s5_q, c_d, c_q;
  logic [4:0]        num_d, num_q;
  logic [7:0]        status;
  logic              grant, post;

  always_comb begin
    status          = '0;
    status[STAT_F]  = f_q;
    status[STAT_5S] = s5_q;
    status[STAT_C]  = c_q;
    status[4:0]     = num_q;
  end

  assign grant = (state_q == ST_PEND) && (access_type_i == AC_CPU);

  always_comb begin
    state_d  = state_q;
    req_wr_d = req_wr_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    latch_d  = latch_q;
    toggle_d = toggle_q;
    cd_d     = cd_q;
    regs_d   = regs_q;
    post     = 1'b0;

    // Completion of the outstanding op; a new post below may re-arm the request.
    if (grant) begin
      if (req_wr_q) begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_IDLE;
      end else begin
        state_d = ST_RDCAP;
      end
    end
    if (state_q == ST_RDCAP) begin
      buf_d   = vram_d_i;
      addr_d  = addr_q + ADDR_W'(1);
      state_d = ST_IDLE;
    end

    if (wr_ctrl) begin
      if (!toggle_q) begin
        latch_d  = cd_i;
        toggle_d = 1'b1;
      end else begin
        toggle_d = 1'b0;
        if (cd_i[7]) begin
          regs_d[cd_i[2:0]] = latch_q;
        end else begin
          addr_d = ADDR_W'({cd_i[5:0], latch_q});
          if (!cd_i[6]) begin
            post     = 1'b1;
            req_wr_d = 1'b0;
          end
        end
      end
    end

    if (wr_data) begin
      buf_d    = cd_i;
      post     = 1'b1;
      req_wr_d = 1'b1;
      toggle_d = 1'b0;
    end

    if (rd_data) begin
      cd_d     = buf_q;
      post     = 1'b1;
      req_wr_d = 1'b0;
      toggle_d = 1'b0;
    end

    if (rd_ctrl) begin
      cd_d     = status;
      toggle_d = 1'b0;
    end

    if (post) state_d = ST_PEND;
  end

  // Flag sets take priority over the clear caused by a status read in the same cycle.
  always_comb begin
    f_d   = irq_i | (f_q & ~rd_ctrl);
    c_d   = spr_coll_i | (c_q & ~rd_ctrl);
    s5_d  = spr_5th_i | (s5_q & ~rd_ctrl);
    num_d = (spr_5th_i && !s5_q) ? spr_5th_num_i : num_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      req_wr_q <= 1'b0;
      addr_q   <= '0;
      buf_q    <= '0;
      latch_q  <= '0;
      toggle_q <= 1'b0;
      cd_q     <= '0;
      f_q      <= 1'b0;
      s5_q     <= 1'b0;
      c_q      <= 1'b0;
      num_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      req_wr_q <= req_wr_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      latch_q  <= latch_d;
      toggle_q <= toggle_d;
      cd_q     <= cd_d;
      f_q      <= f_d;
      s5_q     <= s5_d;
      c_q      <= c_d;
      num_q    <= num_d;
      regs_q   <= regs_d;
    end
  end

`ifdef VDP18_IRQ_EN
  logic int_n_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) int_n_q <= 1'b1;
    else         int_n_q <= ~(f_q & regs_q[1][5]);
  end
  assign int_n_o = int_n_q;
`else
  assign int_n_o = 1'b1;
`endif

  assign vram_we_o = grant & req_wr_q & ~reset_i;
  assign vram_a_o  = addr_q;
  assign vram_d_o  = buf_q;
  assign cd_o      = cd_q;
  assign opmode_o  = decode_opmode(regs_q[0], regs_q[1]);

  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];
  assign reg4_o = regs_q[4];
  assign reg5_o = regs_q[5];
  assign reg6_o = regs_q[6];
  assign reg7_o = regs_q[7];

endmodule

// File: tb/tb_vdp18_cpuio.sv
// Self-checking bench for vdp18_cpuio: VRAM model, periodic AC_CPU slots, and scoreboards
// of expected VRAM writes and CPU read data.
module tb_vdp18_cpuio;
  import vdp18_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        mode = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  cd_i = '0;
  logic [7:0]  cd_o;
  access_t     access_type = AC_NONE;
  logic [13:0] vram_a;
  logic [7:0]  vram_d_o, vram_d_i;
  logic        vram_we;
  logic        irq = 1'b0, spr_coll = 1'b0, spr_5th = 1'b0;
  logic [4:0]  spr_5th_num = '0;
  logic [7:0]  reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  opmode_t     opmode;
  logic        int_n;

  always #5 clk = ~clk;

  vdp18_cpuio dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .mode_i        (mode),
    .rd_n_i        (rd_n),
    .wr_n_i        (wr_n),
    .cd_i          (cd_i),
    .cd_o          (cd_o),
    .access_type_i (access_type),
    .vram_a_o      (vram_a),
    .vram_d_o      (vram_d_o),
    .vram_d_i      (vram_d_i),
    .vram_we_o     (vram_we),
    .irq_i         (irq),
    .spr_coll_i    (spr_coll),
    .spr_5th_i     (spr_5th),
    .spr_5th_num_i (spr_5th_num),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .reg4_o        (reg4),
    .reg5_o        (reg5),
    .reg6_o        (reg6),
    .reg7_o        (reg7),
    .opmode_o      (opmode),
    .int_n_o       (int_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  int         we_count = 0;

  // VRAM model with a bench-side preload port.
  logic [7:0]  mem [16384];
  logic        pre_en = 1'b0;
  logic [13:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  assign vram_d_i = mem[vram_a];

  always @(posedge clk) begin
    if (pre_en)       mem[pre_a] <= pre_d;
    else if (vram_we) mem[vram_a] <= vram_d_o;
  end

  // Access sequencer stand-in: AC_CPU every third cycle when enabled.
  logic grant_en = 1'b1;
  int   cyc = 0;
  always @(negedge clk) begin
    cyc++;
    access_type = (grant_en && (cyc % 3 == 0)) ? AC_CPU : AC_NONE;
  end

  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      wr_t e;
      we_count++;
      if (exp_wr.size() == 0) begin
        check_eq("unexpected_we", 32'(vram_a), 32'hFFFF);
      end else begin
        e = exp_wr.pop_front();
        check_eq("we_addr", 32'(vram_a), 32'(e.a));
        check_eq("we_data", 32'(vram_d_o), 32'(e.d));
      end
    end
  end

  task automatic cpu_write(input logic m, input logic [7:0] d);
    @(negedge clk);
    mode = m; cd_i = d; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_read(input logic m, output logic [7:0] d);
    @(negedge clk);
    mode = m; rd_n = 1'b0;
    repeat (3) @(negedge clk);
    rd_n = 1'b1;
    repeat (2) @(negedge clk);
    d = cd_o;
  endtask

  task automatic ctrl(input logic [7:0] b0, input logic [7:0] b1);
    cpu_write(1'b1, b0);
    cpu_write(1'b1, b1);
  endtask

  task automatic read_and_score(input logic m, input string tag);
    logic [7:0] d;
    cpu_read(m, d);
    if (exp_rd.size() == 0) check_eq({tag, "_noexp"}, 32'(d), 32'hFFFF);
    else                    check_eq(tag, 32'(d), 32'(exp_rd.pop_front()));
  endtask

  task automatic data_write(input logic [13:0] a, input logic [7:0] d);
    exp_wr.push_back('{a: a, d: d});
    cpu_write(1'b0, d);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && exp_wr.size() != 0; i++) @(negedge clk);
    check_eq(tag, 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  logic exp_int_low;
  int   we_before;

  initial begin
`ifdef VDP18_IRQ_EN
    exp_int_low = 1'b0;
`else
    exp_int_low = 1'b1;
`endif
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("rst_reg1", 32'(reg1), 32'h0);
    check_eq("rst_vram_a", 32'(vram_a), 32'h0);
    check_eq("rst_cd_o", 32'(cd_o), 32'h0);
    check_eq("rst_we", 32'(vram_we), 32'h0);
    check_eq("rst_int_n", 32'(int_n), 32'h1);
    check_eq("rst_opmode", 32'(opmode), 32'(OPMODE_GRAPH1));

    // Register writes and opmode priority
    ctrl(8'h82, 8'h81);
    check_eq("reg1_82", 32'(reg1), 32'h82);
    check_eq("opm_g1", 32'(opmode), 32'(OPMODE_GRAPH1));
    ctrl(8'h18, 8'h81);
    check_eq("opm_textm", 32'(opmode), 32'(OPMODE_TEXTM));
    ctrl(8'h08, 8'h81);
    check_eq("opm_multic", 32'(opmode), 32'(OPMODE_MULTIC));
    ctrl(8'h02, 8'h80);
    check_eq("reg0_02", 32'(reg0), 32'h02);
    check_eq("opm_multic2", 32'(opmode), 32'(OPMODE_MULTIC));
    ctrl(8'h00, 8'h81);
    check_eq("opm_g2", 32'(opmode), 32'(OPMODE_GRAPH2));
    ctrl(8'h3C, 8'h87);
    check_eq("reg7_3c", 32'(reg7), 32'h3C);

    // Status read resets the byte toggle
    cpu_write(1'b1, 8'h55);
    exp_rd.push_back(8'h00);
    read_and_score(1'b1, "stat_clean");
    ctrl(8'h87, 8'h81);
    check_eq("reg1_87", 32'(reg1), 32'h87);
    check_eq("reg7_kept", 32'(reg7), 32'h3C);

    // Sequential VRAM writes
    ctrl(8'h00, 8'h40);
    check_eq("addr_0000", 32'(vram_a), 32'h0000);
    data_write(14'h0000, 8'hAA);
    drain("drain_aa");
    data_write(14'h0001, 8'hBB);
    drain("drain_bb");
    check_eq("addr_0002", 32'(vram_a), 32'h0002);

    // Address wrap
    ctrl(8'hFF, 8'h7F);
    check_eq("addr_3fff", 32'(vram_a), 32'h3FFF);
    data_write(14'h3FFF, 8'h11);
    drain("drain_11");
    data_write(14'h0000, 8'h22);
    drain("drain_22");
    check_eq("addr_wrap", 32'(vram_a), 32'h0001);

    // Read-ahead
    preload(14'h0123, 8'h5A);
    preload(14'h0124, 8'hC3);
    ctrl(8'h23, 8'h01);
    repeat (10) @(negedge clk);
    check_eq("prefetch_addr", 32'(vram_a), 32'h0124);
    exp_rd.push_back(8'h5A);
    read_and_score(1'b0, "rd_5a");
    repeat (10) @(negedge clk);
    check_eq("next_prefetch", 32'(vram_a), 32'h0125);
    exp_rd.push_back(8'hC3);
    read_and_score(1'b0, "rd_c3");
    repeat (10) @(negedge clk);
    check_eq("addr_0126", 32'(vram_a), 32'h0126);

    // Interrupt flag and status
    ctrl(8'h20, 8'h81);
    @(negedge clk); irq = 1'b1;
    @(negedge clk); irq = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("int_asserted", 32'(int_n), 32'(exp_int_low));
    exp_rd.push_back(8'h80);
    read_and_score(1'b1, "stat_f");
    repeat (2) @(negedge clk);
    check_eq("int_released", 32'(int_n), 32'h1);
    exp_rd.push_back(8'h00);
    read_and_score(1'b1, "stat_f_clr");

    // Sprite flags: 5th-sprite number latched only while 5S is clear
    @(negedge clk); spr_5th = 1'b1; spr_5th_num = 5'h0B; spr_coll = 1'b1;
    @(negedge clk); spr_5th_num = 5'h03; spr_coll = 1'b0;
    @(negedge clk); spr_5th = 1'b0;
    exp_rd.push_back(8'h6B);
    read_and_score(1'b1, "stat_spr");
    exp_rd.push_back(8'h0B);
    read_and_score(1'b1, "stat_spr_clr");

    // Reset while a write is pending
    grant_en = 1'b0;
    ctrl(8'h00, 8'h50);
    cpu_write(1'b0, 8'h77);
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    we_before = we_count;
    grant_en = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("no_we_after_rst", 32'(we_count - we_before), 32'd0);
    check_eq("rst2_addr", 32'(vram_a), 32'h0);
    check_eq("rst2_cd_o", 32'(cd_o), 32'h0);
    check_eq("rst2_reg1", 32'(reg1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
